cache_line_mover: RTL and testbench

- Line-transfer engine between the 8 KB, 64-bit byte-enabled cache data array and the external bus.
- On request it can write back a victim line (array -> bus), then refill the line (bus -> array).
- It drives the array's read port (1-cycle registered read latency) and its write port (address, data, byte select, write enable).
- Sits in the BIU between the cache controller and the bus master.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_line_mover.sv | 202 ++++++++++++++++++++
 tb/tb_cache_line_mover.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache line mover and the 8 KB byte-enabled cache data array.
// Holds the mover state encoding and the array/line geometry.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WB_RD     = 3'd1,
    ST_WB_CAP    = 3'd2,
    ST_WB_SEND   = 3'd3,
    ST_FILL_REQ  = 3'd4,
    ST_FILL_DATA = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam int BEAT_BYTES = 8;
  localparam int LANE_BITS  = $clog2(BEAT_BYTES);
  localparam int ARR_AW     = 13;
  localparam int ARR_DW     = 64;
  localparam int ARR_LANES  = ARR_DW / 8;

  function automatic int line_ofs_bits(input int line_beats);
    return $clog2(line_beats * BEAT_BYTES);
  endfunction

  localparam int LINE_BEATS_DFLT = 4;
  localparam int LINE_OFS_BITS   = line_ofs_bits(LINE_BEATS_DFLT);

endpackage

// File: rtl/cache_line_mover.sv
// Moves one cache line between the data array and the external bus: optional victim
// writeback (array -> bus) followed by optional refill (bus -> array).
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int AW         = ARR_AW,
  parameter int BAW        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wb,
  input  logic                 req_fill,
  input  logic [AW-1:0]        req_line,
  input  logic [BAW-1:0]       req_wb_addr,
  input  logic [BAW-1:0]       req_fill_addr,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        c_raddr,
  input  logic [ARR_DW-1:0]    c_rdata,
  output logic [AW-1:0]        c_waddr,
  output logic [ARR_DW-1:0]    c_wdata,
  output logic                 c_we,
  output logic [ARR_LANES-1:0] c_bsel,
  output logic                 bus_wvalid,
  input  logic                 bus_wready,
  output logic [BAW-1:0]       bus_waddr,
  output logic [ARR_DW-1:0]    bus_wdata,
  output logic                 bus_wlast,
  output logic                 bus_rreq,
  output logic [BAW-1:0]       bus_raddr,
  input  logic                 bus_rvalid,
  input  logic [ARR_DW-1:0]    bus_rdata,
  input  logic                 bus_rlast,
  output state_t               dbg_state
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam logic [AW-1:0]  A_OFS_MASK = AW'(LINE_BEATS * BEAT_BYTES - 1);
  localparam logic [BAW-1:0] B_OFS_MASK = BAW'(LINE_BEATS * BEAT_BYTES - 1);
  localparam logic [BW-1:0]  LAST_BEAT  = BW'(LINE_BEATS - 1);

  // Beat offset only spans the in-line bits, so line + offset never carries past the base.
  function automatic logic [AW-1:0] beat_ofs(input logic [BW-1:0] b);
    return AW'({b, {LANE_BITS{1'b0}}});
  endfunction

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [AW-1:0]        line_q, line_d;
  logic [BAW-1:0]       wb_addr_q, wb_addr_d;
  logic [BAW-1:0]       fill_addr_q, fill_addr_d;
  logic                 fill_flag_q, fill_flag_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [ARR_DW-1:0]    wb_buf_q, wb_buf_d;
  logic [AW-1:0]        c_raddr_q, c_raddr_d;
  logic [AW-1:0]        c_waddr_q, c_waddr_d;
  logic [ARR_DW-1:0]    c_wdata_q, c_wdata_d;
  logic                 c_we_q, c_we_d;
  logic [ARR_LANES-1:0] c_bsel_q, c_bsel_d;
  logic                 bus_wvalid_q, bus_wvalid_d;
  logic                 bus_wlast_q, bus_wlast_d;
  logic                 bus_rreq_q, bus_rreq_d;

  // Handshakes: a request is taken on a clock edge where req_valid && req_ready; a
  // writeback beat is taken where bus_wvalid && bus_wready, with bus_wdata/bus_wlast held
  // until then; refill beats have no backpressure and are taken on every bus_rvalid.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    wb_addr_d   = wb_addr_q;
    fill_addr_d = fill_addr_q;
    fill_flag_d = fill_flag_q;
    err_d       = err_q;
    wb_buf_d    = wb_buf_q;
    done_d      = (state_q == ST_DONE);
    c_waddr_d   = '0;
    c_wdata_d   = '0;
    c_we_d      = 1'b0;
    c_bsel_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          line_d      = req_line & ~A_OFS_MASK;
          wb_addr_d   = req_wb_addr & ~B_OFS_MASK;
          fill_addr_d = req_fill_addr & ~B_OFS_MASK;
          fill_flag_d = req_fill;
          err_d       = 1'b0;
          beat_d      = '0;
          if (req_wb)        state_d = ST_WB_RD;
          else if (req_fill) state_d = ST_FILL_REQ;
          else               state_d = ST_DONE;
        end
      end
      ST_WB_RD:  state_d = ST_WB_CAP;
      ST_WB_CAP: begin
        wb_buf_d = c_rdata;
        state_d  = ST_WB_SEND;
      end
      ST_WB_SEND: begin
        if (bus_wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = fill_flag_q ? ST_FILL_REQ : ST_DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_WB_RD;
          end
        end
      end
      ST_FILL_REQ: begin
        beat_d  = '0;
        state_d = ST_FILL_DATA;
      end
      ST_FILL_DATA: begin
        if (bus_rvalid) begin
          c_we_d    = 1'b1;
          c_bsel_d  = '1;
          c_waddr_d = line_q | beat_ofs(beat_q);
          c_wdata_d = bus_rdata;
          beat_d    = beat_q + 1'b1;
          // A missing rlast still completes the line; an early rlast truncates it.
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
            if (!bus_rlast) err_d = 1'b1;
          end else if (bus_rlast) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    c_raddr_d    = (state_d == ST_WB_RD) ? (line_d | beat_ofs(beat_d)) : '0;
    bus_wvalid_d = (state_d == ST_WB_SEND);
    bus_wlast_d  = (state_d == ST_WB_SEND) && (beat_d == LAST_BEAT);
    bus_rreq_d   = (state_d == ST_FILL_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      line_q       <= '0;
      wb_addr_q    <= '0;
      fill_addr_q  <= '0;
      fill_flag_q  <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      wb_buf_q     <= '0;
      c_raddr_q    <= '0;
      c_waddr_q    <= '0;
      c_wdata_q    <= '0;
      c_we_q       <= 1'b0;
      c_bsel_q     <= '0;
      bus_wvalid_q <= 1'b0;
      bus_wlast_q  <= 1'b0;
      bus_rreq_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      wb_addr_q    <= wb_addr_d;
      fill_addr_q  <= fill_addr_d;
      fill_flag_q  <= fill_flag_d;
      err_q        <= err_d;
      done_q       <= done_d;
      wb_buf_q     <= wb_buf_d;
      c_raddr_q    <= c_raddr_d;
      c_waddr_q    <= c_waddr_d;
      c_wdata_q    <= c_wdata_d;
      c_we_q       <= c_we_d;
      c_bsel_q     <= c_bsel_d;
      bus_wvalid_q <= bus_wvalid_d;
      bus_wlast_q  <= bus_wlast_d;
      bus_rreq_q   <= bus_rreq_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign c_raddr    = c_raddr_q;
  assign c_waddr    = c_waddr_q;
  assign c_wdata    = c_wdata_q;
  assign c_we       = c_we_q;
  assign c_bsel     = c_bsel_q;
  assign bus_wvalid = bus_wvalid_q;
  assign bus_waddr  = wb_addr_q;
  assign bus_wdata  = wb_buf_q;
  assign bus_wlast  = bus_wlast_q;
  assign bus_rreq   = bus_rreq_q;
  assign bus_raddr  = fill_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: a table of line-transfer requests with
// hand-computed outcomes, plus a reset-during-refill sequence.
module tb_cache_line_mover;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
  logic [12:0] req_line = '0;
  logic [31:0] req_wb_addr = '0, req_fill_addr = '0;
  logic        req_ready, done, err, c_we, bus_wvalid, bus_wlast, bus_rreq;
  logic [12:0] c_raddr, c_waddr;
  logic [63:0] c_rdata = '0, c_wdata, bus_wdata;
  logic [7:0]  c_bsel;
  logic        bus_wready = 1'b1, bus_rvalid = 1'b0, bus_rlast = 1'b0;
  logic [31:0] bus_waddr, bus_raddr;
  logic [63:0] bus_rdata = '0;
  state_t      dbg_state;

  cache_line_mover dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill), .req_line(req_line),
    .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
    .done(done), .err(err), .c_raddr(c_raddr), .c_rdata(c_rdata),
    .c_waddr(c_waddr), .c_wdata(c_wdata), .c_we(c_we), .c_bsel(c_bsel),
    .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata), .bus_wlast(bus_wlast), .bus_rreq(bus_rreq),
    .bus_raddr(bus_raddr), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_rlast(bus_rlast), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- array model: registered read, byte-enabled write ----------------
  logic [63:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;

  always @(posedge clk) begin
    c_rdata <= mem[c_raddr[12:3]];
    if (pl_we) mem[pl_idx] <= pl_data;
    if (c_we) begin
      for (int b = 0; b < 8; b++)
        if (c_bsel[b]) mem[c_waddr[12:3]][b*8 +: 8] <= c_wdata[b*8 +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [76:0] exp_q[$];
  logic [63:0] exp_wb_q[$];
  logic [12:0] exp_raddr_q[$];
  int          exp_wcyc_q[$];

  function automatic logic [63:0] fill_data(input int idx, input int k);
    return 64'hD000_0000_0000_0000 | (64'(idx) << 8) | 64'(k);
  endfunction

  function automatic logic [63:0] wb_data(input int idx, input int k);
    return 64'hA000_0000_0000_0000 | (64'(idx) << 8) | 64'(k);
  endfunction

  // ---------------- monitor ----------------
  bit          mon_en = 1'b0;
  bit          cur_wb = 1'b0;
  logic [31:0] cur_wb_addr = '0, cur_fill_addr = '0;
  int wr_cnt, wb_hs, rreq_cnt, done_cnt, wv_cnt, last_we_cyc;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (c_we) begin
        wr_cnt++;
        last_we_cyc = cyc;
        chk("write_expected", 256'(exp_q.size() != 0), 256'(1));
        chk("write_bsel", c_bsel, 8'hFF);
        if (exp_q.size() != 0) chk("write_addr_data", {c_waddr, c_wdata}, exp_q.pop_front());
        if (exp_wcyc_q.size() != 0) chk("write_cycle", cyc, exp_wcyc_q.pop_front());
      end else begin
        chk("bsel_idle", c_bsel, 8'h00);
      end
      if (dbg_state == ST_WB_RD) begin
        chk("raddr_expected", 256'(exp_raddr_q.size() != 0), 256'(1));
        if (exp_raddr_q.size() != 0) chk("c_raddr", c_raddr, exp_raddr_q.pop_front());
      end
      if (bus_wvalid) begin
        wv_cnt++;
        chk("wb_expected", 256'(exp_wb_q.size() != 0), 256'(1));
        if (exp_wb_q.size() != 0) begin
          chk("wb_waddr", bus_waddr, cur_wb_addr);
          chk("wb_wlast", bus_wlast, exp_wb_q.size() == 1);
          if (bus_wready) chk("wb_wdata", bus_wdata, exp_wb_q.pop_front());
          else chk("wb_wdata_stall", bus_wdata, exp_wb_q[0]);
        end
        if (bus_wready) wb_hs++;
      end
      if (bus_rreq) begin
        rreq_cnt++;
        chk("rreq_raddr", bus_raddr, cur_fill_addr);
        chk("rreq_after_wb", wb_hs, cur_wb ? 4 : 0);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        wb;
    logic        fill;
    logic [12:0] line;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
    int          nbeats;
    int          rlast_beat;
    int          stall_beat;
    int          stall_cycles;
    int          exp_writes;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk_idle(input string name);
    chk({name, "_outs"}, {done, err, c_raddr, c_waddr, c_wdata, c_we, c_bsel, bus_wvalid,
        bus_waddr, bus_wdata, bus_wlast, bus_rreq, bus_raddr}, '0);
    chk({name, "_ready"}, req_ready, 1'b1);
  endtask

  task automatic send_req(input vec_t v);
    req_valid = 1'b1; req_wb = v.wb; req_fill = v.fill;
    req_line = v.line; req_wb_addr = v.wb_addr; req_fill_addr = v.fill_addr;
    tick();
    req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int acc_cyc, done_cyc, fbeat, stall_left, widx;
    bit filling;
    logic [12:0] line_m;
    line_m        = v.line & ~13'h1F;
    cur_wb        = v.wb;
    cur_wb_addr   = v.wb_addr & ~32'h1F;
    cur_fill_addr = v.fill_addr & ~32'h1F;
    wr_cnt = 0; wb_hs = 0; rreq_cnt = 0; done_cnt = 0; wv_cnt = 0; last_we_cyc = -100;
    if (v.wb) begin
      for (int k = 0; k < 4; k++) begin
        pl_we = 1'b1; pl_idx = 10'(int'(line_m >> 3) + k); pl_data = wb_data(idx, k);
        tick();
        exp_raddr_q.push_back(line_m + 13'(k * 8));
        exp_wb_q.push_back(wb_data(idx, k));
      end
      pl_we = 1'b0;
    end
    for (int k = 0; k < v.exp_writes; k++)
      exp_q.push_back({line_m + 13'(k * 8), fill_data(idx, k)});

    acc_cyc = cyc;
    send_req(v);
    chk("busy_after_accept", req_ready, 1'b0);
    chk("err_clear_on_accept", err, 1'b0);

    done_cyc = -1; fbeat = 0; filling = 1'b0; stall_left = v.stall_cycles;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      bus_wready = 1'b1;
      if (bus_wvalid && wb_hs == v.stall_beat && stall_left > 0) begin
        bus_wready = 1'b0;
        stall_left--;
      end
      bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = '0;
      if (filling && fbeat < v.nbeats) begin
        bus_rvalid = 1'b1;
        bus_rdata  = fill_data(idx, fbeat);
        bus_rlast  = (fbeat == v.rlast_beat);
        if (fbeat < v.exp_writes) exp_wcyc_q.push_back(cyc + 1);
        fbeat++;
      end
      if (bus_rreq) filling = 1'b1;
      tick();
    end
    bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_wready = 1'b1;

    if (done_cyc < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (v.exp_lat > 0) chk("done_latency", done_cyc - acc_cyc, v.exp_lat);
      if (v.exp_writes > 0) chk("done_after_last_write", done_cyc, last_we_cyc + 1);
      chk("err_final", err, v.exp_err);
      chk("write_count", wr_cnt, v.exp_writes);
      chk("wb_handshakes", wb_hs, v.wb ? 4 : 0);
      chk("rreq_count", rreq_cnt, v.fill ? 1 : 0);
      if (!v.wb) chk("no_wvalid", wv_cnt, 0);
      chk("queues_drained", exp_q.size() + exp_wb_q.size() + exp_raddr_q.size(), 0);
      for (int k = 0; k < v.exp_writes; k++) begin
        widx = int'(line_m >> 3) + k;
        chk("array_contents", mem[widx], fill_data(idx, k));
      end
      tick();
      chk("done_one_cycle", done, 1'b0);
      chk("done_pulses", done_cnt, 1);
      chk("ready_after_done", req_ready, 1'b1);
    end
    exp_q.delete(); exp_wb_q.delete(); exp_raddr_q.delete(); exp_wcyc_q.delete();
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];

  initial begin
    int fbeat;
    bit filling;
    vec_t rv;
    //          wb    fill  line      wb_addr        fill_addr      nb rl  stb stc wr err  lat
    vecs[0] = '{1'b0, 1'b1, 13'h0040, 32'h0,         32'h8000_0000, 4, 3, -1, 0, 4, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 13'h0100, 32'h4000_0100, 32'h0,         0, 3, -1, 0, 0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b1, 13'h027F, 32'h1234_567F, 32'hCAFE_0013, 4, 3,  1, 5, 4, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 13'h1FE0, 32'h0,         32'h9000_0040, 3, 2, -1, 0, 3, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b0, 13'h0000, 32'h5555_0000, 32'h6666_0000, 0, 3, -1, 0, 0, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b1, 13'h00A7, 32'h0,         32'h7000_1020, 5, 9, -1, 0, 4, 1'b1, 0};

    // power-on reset
    #1;
    chk_idle("in_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("after_reset");
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // reset during refill beat 2, then a normal transfer
    mon_en = 1'b0;
    rv = vecs[0];
    rv.line = 13'h0300;
    send_req(rv);
    fbeat = 0; filling = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (filling && fbeat == 2) break;
      bus_rvalid = 1'b0; bus_rdata = '0;
      if (filling) begin
        bus_rvalid = 1'b1; bus_rdata = fill_data(9, fbeat);
        fbeat++;
      end
      if (bus_rreq) filling = 1'b1;
      tick();
    end
    chk("reached_fill_beat2", fbeat, 2);
    bus_rvalid = 1'b1; bus_rdata = fill_data(9, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid = 1'b0; bus_rdata = '0;
    tick();
    chk_idle("post_abort");
    mon_en = 1'b1;
    run_vec(6, vecs[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
